// File: rtl/sram_arb_pkg.sv
// Shared types and defaults for the cartridge SRAM arbiter.
package sram_arb_pkg;

  localparam int unsigned ACCESS_TICKS_DEFAULT = 4;
  localparam int unsigned TICK_W               = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RECOVER = 2'd2
  } state_t;

  typedef enum logic {
    PORT_COCO = 1'b0,
    PORT_SPI  = 1'b1
  } port_t;

endpackage

// File: rtl/sram_arbiter_if.sv
// Requester handshakes plus SRAM pin bundle; slave = arbiter view, master = board/requester view.
interface sram_arbiter_if #(
  parameter int unsigned ADDR_W = 16
);

  logic              c_req;
  logic              c_we;
  logic [ADDR_W-1:0] c_addr;
  logic [7:0]        c_wdata;
  logic              c_ack;

  logic              s_req;
  logic              s_we;
  logic [ADDR_W-1:0] s_addr;
  logic [7:0]        s_wdata;
  logic              s_ack;

  logic [7:0]        rdata;
  logic              busy;

  logic [ADDR_W-1:0] m_addr;
  logic [7:0]        m_dout;
  logic              m_dout_en;
  logic [7:0]        m_din;
  logic              m_we_n;
  logic              m_oe_n;
  logic              m_cs_n;

  modport slave (
    input  c_req, c_we, c_addr, c_wdata,
    input  s_req, s_we, s_addr, s_wdata,
    input  m_din,
    output c_ack, s_ack, rdata, busy,
    output m_addr, m_dout, m_dout_en, m_we_n, m_oe_n, m_cs_n
  );

  modport master (
    output c_req, c_we, c_addr, c_wdata,
    output s_req, s_we, s_addr, s_wdata,
    output m_din,
    input  c_ack, s_ack, rdata, busy,
    input  m_addr, m_dout, m_dout_en, m_we_n, m_oe_n, m_cs_n
  );

endinterface

// File: rtl/sram_arbiter.sv
// Round-robin arbiter for the Coco and SPI ports, sole owner of the shared
// asynchronous SRAM pins; every output is registered.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned ACCESS_TICKS = ACCESS_TICKS_DEFAULT,
  parameter int unsigned ADDR_W       = 16
) (
  input  logic          clock_50,
  input  logic          reset,
  sram_arbiter_if.slave bus
);

  localparam logic [TICK_W-1:0] TICKS_LOAD = TICK_W'(ACCESS_TICKS);
  localparam logic [TICK_W-1:0] TICK_ONE   = TICK_W'(1);

  state_t            state;
  port_t             last_grant;
  logic [TICK_W-1:0] ticks;

  port_t             grant_port;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [7:0]        sel_wdata;

  // On a tie the port that did not win last time is chosen.
  always_comb begin
    grant_port = PORT_SPI;
    if (bus.c_req && bus.s_req) begin
      grant_port = (last_grant == PORT_SPI) ? PORT_COCO : PORT_SPI;
    end else if (bus.c_req) begin
      grant_port = PORT_COCO;
    end
    sel_we    = (grant_port == PORT_COCO) ? bus.c_we    : bus.s_we;
    sel_addr  = (grant_port == PORT_COCO) ? bus.c_addr  : bus.s_addr;
    sel_wdata = (grant_port == PORT_COCO) ? bus.c_wdata : bus.s_wdata;
  end

  always_ff @(posedge clock_50 or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      last_grant    <= PORT_SPI;
      ticks         <= '0;
      bus.busy      <= 1'b0;
      bus.c_ack     <= 1'b0;
      bus.s_ack     <= 1'b0;
      bus.rdata     <= '0;
      bus.m_addr    <= '0;
      bus.m_dout    <= '0;
      bus.m_dout_en <= 1'b0;
      bus.m_we_n    <= 1'b1;
      bus.m_oe_n    <= 1'b1;
      bus.m_cs_n    <= 1'b1;
    end else begin
      bus.c_ack <= 1'b0;
      bus.s_ack <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.c_req || bus.s_req) begin
            last_grant    <= grant_port;
            bus.m_addr    <= sel_addr;
            bus.m_dout    <= sel_wdata;
            bus.m_dout_en <= sel_we;
            bus.m_we_n    <= ~sel_we;
            bus.m_oe_n    <= sel_we;
            bus.m_cs_n    <= 1'b0;
            ticks         <= TICKS_LOAD;
            bus.busy      <= 1'b1;
            state         <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          ticks <= ticks - TICK_ONE;
          if (ticks == TICK_ONE) begin
            if (!bus.m_dout_en) begin
              bus.rdata <= bus.m_din;
            end
            bus.m_we_n <= 1'b1;
            bus.m_oe_n <= 1'b1;
            bus.m_cs_n <= 1'b1;
            bus.c_ack  <= (last_grant == PORT_COCO);
            bus.s_ack  <= (last_grant == PORT_SPI);
            state      <= ST_RECOVER;
          end
        end
        ST_RECOVER: begin
          // Address, data and driver enable stay put one cycle past the strobes.
          bus.m_dout_en <= 1'b0;
          bus.busy      <= 1'b0;
          state         <= ST_IDLE;
        end
        default: begin
          bus.m_dout_en <= 1'b0;
          bus.m_we_n    <= 1'b1;
          bus.m_oe_n    <= 1'b1;
          bus.m_cs_n    <= 1'b1;
          bus.busy      <= 1'b0;
          state         <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
